nonce_sweep_ctrl: RTL and testbench
===================================

# nonce_sweep_ctrl

Sequencing controller for the SHA-256 core in the mining accelerator.
- Takes a 512-bit message block, a nonce range and a difficulty from the software-facing register file.
- Repeatedly loads the block into the `sha256_module` with the next nonce substituted, starts the core, and checks each digest for the required leading zero bits.
- Stops on the first match, on range exhaustion or on abort, and reports the result.
- Sits between the Avalon register front end and the `sha256_module` instance, and owns that core's `start` and `reset` inputs.

## Interface
Parameters:
- `NONCE_WORD`, default 3: index of the 32-bit word of the block replaced by the nonce, i.e. bits `[32*NONCE_WORD+31 : 32*NONCE_WORD]`.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit on a single hash. Used only with `NONCE_SWEEP_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: synchronous, active-low reset.
- `block_in` in 512: message block, sampled on `go`.
- `nonce_lo` in 32: first nonce, inclusive; sampled on `go`.
- `nonce_hi` in 32: last nonce, inclusive; sampled on `go`.
- `zero_bits` in 8: required count of leading zero bits from `hash[255]` downward; sampled on `go`.
- `go` in 1: one-cycle sweep request.
- `abort` in 1: one-cycle stop request.
- `busy` out 1: sweep in progress.
- `found` out 1: the sweep ended on a match.
- `exhausted` out 1: the range completed with no match.
- `aborted` out 1: the sweep was stopped by `abort`.
- `timeout` out 1: watchdog fired.
- `found_nonce` out 32: nonce of the match.
- `found_hash` out 256: digest of the match.
- `hash_count` out 32: number of digests checked in the current or last sweep.
- `core_data` out 512: block driven to the core.
- `core_start` out 1: core start pulse.
- `core_reset` out 1: active-high reset to the core.
- `core_hash` in 256: digest from the core.
- `core_done` in 1: core completion; held high until the core is reset.

## Operation
State sequence and transitions:
- **IDLE:** on `go`, latch all `*_in`/`nonce_*`/`zero_bits` inputs. Clear `found`/`exhausted`/`aborted`/`timeout`/`hash_count`. Set `cur_nonce=nonce_lo` and go to LOAD.
  - If `nonce_lo > nonce_hi` (unsigned), go directly to DONE with `exhausted=1` and `hash_count=0`. The core is never started.
- **LOAD:** register `core_data` = latched block with word `NONCE_WORD` replaced by `cur_nonce`. Go to START.
- **START:** `core_start=1` for exactly one cycle. Go to WAIT.
- **WAIT:** hold `core_data` stable. On `core_done=1`, go to CHECK.
- **CHECK:** increment `hash_count`. Match when `core_hash[255 -: zero_bits]` are all zero; `zero_bits=0` always matches.
  - On a match: `found=1`, `found_nonce=cur_nonce`, `found_hash=core_hash`, go to DONE.
  - Else if `cur_nonce==nonce_hi`: `exhausted=1`, go to DONE.
  - Else: `cur_nonce+1`, go to CLEAR.
- **CLEAR:** `core_reset=1` for one cycle. Go to LOAD.
- **DONE:** `core_reset=1` for its first cycle only.
  - Result outputs hold until the next accepted `go`.
  - `go` in DONE behaves as `go` in IDLE.

Rules and boundary conditions:
- `busy=1` in LOAD, START, WAIT, CHECK and CLEAR.
- `go` while `busy` is ignored.
- `abort` while `busy` takes priority over every transition. Next state is DONE with `aborted=1` and `found`/`exhausted` at 0. `hash_count` keeps its value; a CHECK in the same cycle does not count.
- `abort` while not busy is ignored.
- `nonce_hi=32'hFFFFFFFF` terminates by the equality test. `cur_nonce` never wraps and no nonce is hashed twice.
- `hash_count` saturates at `32'hFFFFFFFF`.
- `core_reset` is also driven high while `reset_n=0`.

## Timing
- Reset (`reset_n=0` at a clock edge):
  - State = IDLE.
  - All outputs 0, except `core_reset=1`.
  - Reset mid-sweep discards the sweep; no result flags are set.
- Latency with `go` at cycle 0:
  - LOAD at cycle 1; `core_start` high at cycle 2.
  - If `core_done` is first seen high at cycle N, CHECK is at N+1 and result flags are visible at N+2.
- Per-nonce overhead is 4 cycles on top of the core latency (CHECK, CLEAR, LOAD, START).
- `core_data` changes only in LOAD and is stable from LOAD through CHECK.

## Configuration
- With `NONCE_SWEEP_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching `TIMEOUT_CYCLES` without `core_done` goes to DONE with `timeout=1` and the core reset.
- Without it:
  - No counter is built; WAIT waits indefinitely.
  - `timeout` is tied to 0.

## Test plan
- `zero_bits=0`, `nonce_lo=nonce_hi=7` -> one `core_start`, `found=1`, `found_nonce=7`, `hash_count=1`, `found_hash` equals the reference SHA-256 of the block.
- `nonce_lo=5`, `nonce_hi=4`, `go` -> `exhausted=1`, `hash_count=0`, no `core_start` pulse.
- `nonce_lo=32'hFFFFFFFE`, `nonce_hi=32'hFFFFFFFF`, `zero_bits=255` -> two hashes, `exhausted=1`, `hash_count=2`, no third `core_start`.
- Sweep 0..100 with `zero_bits=255`; `abort` during the 3rd WAIT -> `aborted=1`, `hash_count=2`, `busy=0` next cycle; a second `go` mid-sweep has no effect.
- Stub core with a known digest having 8 leading zero bits at nonce 3, `zero_bits=8`, range 0..10 -> `found_nonce=3`, `hash_count=4`; `zero_bits=9` -> `exhausted=1`, `hash_count=11`.
- `NONCE_SWEEP_TIMEOUT_EN` defined, `TIMEOUT_CYCLES=16`, stub that never asserts `core_done` -> `timeout=1` 16 cycles after entry to WAIT, `core_reset` pulsed, `busy=0`.

Source files
------------

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: drives a SHA-256 core across a nonce range, loading the
// block with each nonce substituted, starting the core and testing each
// digest for the requested number of leading zero bits. Stops on the first
// match, at the end of the range, on abort, or (optionally) on a hang.
//
// Build option: define NONCE_SWEEP_TIMEOUT_EN to add a per-hash watchdog of
// TIMEOUT_CYCLES cycles spent waiting for core_done.
module nonce_sweep_ctrl #(
  parameter int unsigned NONCE_WORD     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [511:0] block_in,
  input  logic [31:0]  nonce_lo,
  input  logic [31:0]  nonce_hi,
  input  logic [7:0]   zero_bits,
  input  logic         go,
  input  logic         abort,
  output logic         busy,
  output logic         found,
  output logic         exhausted,
  output logic         aborted,
  output logic         timeout,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  output logic [31:0]  hash_count,
  output logic [511:0] core_data,
  output logic         core_start,
  output logic         core_reset,
  input  logic [255:0] core_hash,
  input  logic         core_done
);

  localparam int unsigned BLK_W     = 512;
  localparam int unsigned HASH_W    = 256;
  localparam int unsigned NONCE_W   = 32;
  localparam int unsigned ZB_W      = 8;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned NONCE_LSB = NONCE_W * NONCE_WORD;

  // Reject configurations that would place the nonce outside the block
  if (NONCE_WORD > 15 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("nonce_sweep_ctrl: NONCE_WORD must be 0..15 and TIMEOUT_CYCLES nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_CHECK,
    S_CLEAR,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [BLK_W-1:0]    blk_q;
  logic [NONCE_W-1:0]  hi_q;
  logic [NONCE_W-1:0]  cur_nonce_q;
  logic [ZB_W-1:0]     zero_bits_q;
  logic                busy_q;
  logic                found_q;
  logic                exhausted_q;
  logic                aborted_q;
  logic [NONCE_W-1:0]  found_nonce_q;
  logic [HASH_W-1:0]   found_hash_q;
  logic [CNT_W-1:0]    hash_count_q;
  logic [BLK_W-1:0]    core_data_q;
  logic                core_start_q;
  logic                core_reset_q;

`ifdef NONCE_SWEEP_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0]     wd_q;
  logic                timeout_q;
`endif

  logic [HASH_W-1:0]   zero_mask;
  logic                hash_match;
  logic [BLK_W-1:0]    load_data;
  logic [CNT_W-1:0]    count_next;

  // Digest test, nonce substitution and saturating count
  always_comb begin
    zero_mask  = ~({HASH_W{1'b1}} >> zero_bits_q);
    hash_match = ((core_hash & zero_mask) == '0);
    load_data  = blk_q;
    load_data[NONCE_LSB +: NONCE_W] = cur_nonce_q;
    count_next = (hash_count_q == '1) ? hash_count_q : hash_count_q + CNT_W'(1);
  end

  // Sweep sequencer with registered status and core controls
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      blk_q         <= '0;
      hi_q          <= '0;
      cur_nonce_q   <= '0;
      zero_bits_q   <= '0;
      busy_q        <= 1'b0;
      found_q       <= 1'b0;
      exhausted_q   <= 1'b0;
      aborted_q     <= 1'b0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      hash_count_q  <= '0;
      core_data_q   <= '0;
      core_start_q  <= 1'b0;
      core_reset_q  <= 1'b1;
`ifdef NONCE_SWEEP_TIMEOUT_EN
      wd_q          <= '0;
      timeout_q     <= 1'b0;
`endif
    end else begin
      core_start_q <= 1'b0;
      core_reset_q <= 1'b0;
      if (busy_q && abort) begin
        // Abort wins over any in-flight transition, including a CHECK
        state_q      <= S_DONE;
        busy_q       <= 1'b0;
        aborted_q    <= 1'b1;
        found_q      <= 1'b0;
        exhausted_q  <= 1'b0;
        core_reset_q <= 1'b1;
      end else begin
        unique case (state_q)
          S_IDLE, S_DONE: begin
            if (go) begin
              blk_q        <= block_in;
              hi_q         <= nonce_hi;
              zero_bits_q  <= zero_bits;
              cur_nonce_q  <= nonce_lo;
              found_q      <= 1'b0;
              aborted_q    <= 1'b0;
              hash_count_q <= '0;
`ifdef NONCE_SWEEP_TIMEOUT_EN
              timeout_q    <= 1'b0;
`endif
              if (nonce_lo > nonce_hi) begin
                state_q      <= S_DONE;
                exhausted_q  <= 1'b1;
                core_reset_q <= 1'b1;
              end else begin
                state_q     <= S_LOAD;
                exhausted_q <= 1'b0;
                busy_q      <= 1'b1;
              end
            end
          end
          S_LOAD: begin
            core_data_q  <= load_data;
            core_start_q <= 1'b1;
            state_q      <= S_START;
          end
          S_START: begin
            state_q <= S_WAIT;
`ifdef NONCE_SWEEP_TIMEOUT_EN
            wd_q    <= '0;
`endif
          end
          S_WAIT: begin
            if (core_done) begin
              state_q <= S_CHECK;
`ifdef NONCE_SWEEP_TIMEOUT_EN
            end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              timeout_q    <= 1'b1;
              core_reset_q <= 1'b1;
            end else begin
              wd_q <= wd_q + WD_W'(1);
`endif
            end
          end
          S_CHECK: begin
            hash_count_q <= count_next;
            if (hash_match) begin
              found_q       <= 1'b1;
              found_nonce_q <= cur_nonce_q;
              found_hash_q  <= core_hash;
              state_q       <= S_DONE;
              busy_q        <= 1'b0;
              core_reset_q  <= 1'b1;
            end else if (cur_nonce_q == hi_q) begin
              exhausted_q  <= 1'b1;
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              core_reset_q <= 1'b1;
            end else begin
              cur_nonce_q  <= cur_nonce_q + NONCE_W'(1);
              state_q      <= S_CLEAR;
              core_reset_q <= 1'b1;
            end
          end
          S_CLEAR: begin
            state_q <= S_LOAD;
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy        = busy_q;
  assign found       = found_q;
  assign exhausted   = exhausted_q;
  assign aborted     = aborted_q;
  assign found_nonce = found_nonce_q;
  assign found_hash  = found_hash_q;
  assign hash_count  = hash_count_q;
  assign core_data   = core_data_q;
  assign core_start  = core_start_q;
  assign core_reset  = core_reset_q;
`ifdef NONCE_SWEEP_TIMEOUT_EN
  assign timeout     = timeout_q;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// Bench for nonce_sweep_ctrl: a stub SHA core whose digest has a known
// leading-zero count per nonce, randomized sweeps against a range model,
// plus directed boundary, abort, reset and (optional) watchdog cases.
`timescale 1ns/1ps
module tb_nonce_sweep_ctrl;

  localparam int unsigned NW = 3;
`ifdef NONCE_SWEEP_TIMEOUT_EN
  localparam int unsigned TO = 16;
`else
  localparam int unsigned TO = 1024;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic [511:0] block_in;
  logic [31:0]  nonce_lo, nonce_hi;
  logic [7:0]   zero_bits;
  logic         go, abort;
  logic         busy, found, exhausted, aborted, timeout;
  logic [31:0]  found_nonce, hash_count;
  logic [255:0] found_hash;
  logic [511:0] core_data;
  logic         core_start, core_reset;
  logic [255:0] core_hash = '0;
  logic         core_done = 1'b0;

  int checks = 0;
  int errors = 0;

  nonce_sweep_ctrl #(.NONCE_WORD(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .block_in(block_in), .nonce_lo(nonce_lo),
    .nonce_hi(nonce_hi), .zero_bits(zero_bits), .go(go), .abort(abort),
    .busy(busy), .found(found), .exhausted(exhausted), .aborted(aborted),
    .timeout(timeout), .found_nonce(found_nonce), .found_hash(found_hash),
    .hash_count(hash_count), .core_data(core_data), .core_start(core_start),
    .core_reset(core_reset), .core_hash(core_hash), .core_done(core_done)
  );

  always #5 clk = ~clk;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stub core and its digest definition ----------------
  logic [31:0]  seed = 32'h0;
  bit           directed_mode = 1'b0;
  bit           stub_hang = 1'b0;
  int unsigned  lat_min = 0, lat_max = 3;

  function automatic int unsigned lz_of(input logic [31:0] n);
    logic [31:0] m;
    if (directed_mode) return (n == 32'd3) ? 8 : 5;
    m = (n ^ seed) * 32'h9E3779B1;
    return {27'd0, m[31:27]};
  endfunction

  // Digest with exactly lz_of(n) leading zero bits
  function automatic logic [255:0] hash_of(input logic [31:0] n);
    logic [255:0] fill;
    int unsigned  lz;
    lz   = lz_of(n);
    fill = {8{n * 32'h85EBCA6B + 32'h01234567}};
    return (256'd1 << (255 - lz)) | (fill >> (lz + 1));
  endfunction

  bit           run = 1'b0;
  int unsigned  lat_cnt = 0;
  logic [511:0] cap_data = '0;
  logic [511:0] seen_data_q[$];
  int           stable_err = 0;

  always @(posedge clk) begin
    if (core_reset) begin
      core_done <= 1'b0;
      run       <= 1'b0;
    end else if (core_start) begin
      run      <= 1'b1;
      lat_cnt  <= $urandom_range(lat_max, lat_min);
      cap_data <= core_data;
      seen_data_q.push_back(core_data);
    end else if (run && !core_done && !stub_hang) begin
      if (lat_cnt == 0) begin
        core_done <= 1'b1;
        core_hash <= hash_of(cap_data[32*NW +: 32]);
        if (core_data !== cap_data) stable_err++;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic wait_idle(input string tag);
    for (int c = 0; c < 5000 && busy; c++) @(negedge clk);
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic rand_block(output logic [511:0] b);
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom();
  endtask

  // One full sweep checked against the range model
  task automatic run_sweep(input logic [31:0] lo, input logic [31:0] hi,
                           input logic [7:0] zb, input string tag);
    logic [511:0] blk, e;
    logic [31:0]  exp_list[$];
    int           exp_cnt, base, bad;
    bit           exp_found, exp_exh;
    logic [31:0]  exp_nonce;
    longint unsigned n;
    rand_block(blk);
    exp_cnt = 0; exp_found = 0; exp_exh = 0; exp_nonce = '0;
    if (lo > hi) begin
      exp_exh = 1;
    end else begin
      n = {32'd0, lo};
      while (n <= {32'd0, hi} && !exp_found) begin
        exp_list.push_back(n[31:0]);
        exp_cnt++;
        if (lz_of(n[31:0]) >= {24'd0, zb}) begin
          exp_found = 1;
          exp_nonce = n[31:0];
        end
        n++;
      end
      exp_exh = !exp_found;
    end
    base = seen_data_q.size();
    @(negedge clk);
    block_in = blk; nonce_lo = lo; nonce_hi = hi; zero_bits = zb; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check_eq({tag, "_busy1"}, busy, (lo <= hi));
    if (lo <= hi) begin
      @(negedge clk);
      check_eq({tag, "_start2"}, core_start, 1'b1);
    end
    wait_idle(tag);
    check_eq({tag, "_found"}, found, exp_found);
    check_eq({tag, "_exh"}, exhausted, exp_exh);
    check_eq({tag, "_abrt"}, aborted, 1'b0);
    check_eq({tag, "_tmo"}, timeout, 1'b0);
    check_eq({tag, "_count"}, hash_count, exp_cnt);
    check_eq({tag, "_starts"}, seen_data_q.size() - base, exp_cnt);
    if (exp_found) begin
      check_eq({tag, "_fnonce"}, found_nonce, exp_nonce);
      check_eq({tag, "_fhash"}, found_hash, hash_of(exp_nonce));
    end
    bad = 0;
    for (int i = 0; i < exp_list.size() && base + i < seen_data_q.size(); i++) begin
      e = blk;
      e[32*NW +: 32] = exp_list[i];
      if (seen_data_q[base + i] !== e) bad++;
    end
    check_eq({tag, "_cdata"}, bad, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] lo, hi;
    logic [7:0]  zb;
    int          nstart, base, k;
    reset_n = 1'b0; block_in = '0; nonce_lo = '0; nonce_hi = '0;
    zero_bits = '0; go = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_flags", {found, exhausted, aborted, timeout}, 4'b0000);
    check_eq("rst_count", hash_count, 32'd0);
    check_eq("rst_fnonce", found_nonce, 32'd0);
    check_eq("rst_fhash", found_hash, 256'd0);
    check_eq("rst_cdata", core_data, 512'd0);
    check_eq("rst_cstart", core_start, 1'b0);
    check_eq("rst_creset", core_reset, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_creset", core_reset, 1'b0);

    // Directed boundaries
    seed = $urandom();
    run_sweep(32'd7, 32'd7, 8'd0, "single7");
    run_sweep(32'd5, 32'd4, 8'd0, "empty");
    run_sweep(32'hFFFFFFFE, 32'hFFFFFFFF, 8'd255, "top");
    directed_mode = 1'b1;
    run_sweep(32'd0, 32'd10, 8'd8, "zb8");
    run_sweep(32'd0, 32'd10, 8'd9, "zb9");
    directed_mode = 1'b0;

    // Abort while not busy leaves the result untouched
    run_sweep(32'd7, 32'd7, 8'd0, "pre_idle_abort");
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_eq("idle_abort", {found, aborted}, 2'b10);

    // Randomized sweeps
    for (int t = 0; t < 24; t++) begin
      seed = $urandom();
      lat_max = $urandom_range(4, 0);
      lo = $urandom() & 32'h7FFFFFFF;
      if ($urandom_range(7, 0) == 0) begin
        lo = lo | 32'h100;
        hi = lo - $urandom_range(5, 1);
      end else begin
        hi = lo + $urandom_range(12, 0);
      end
      zb = 8'($urandom_range(34, 0));
      run_sweep(lo, hi, zb, $sformatf("rnd%0d", t));
    end

    // Abort during the third WAIT, with an ignored go mid-sweep
    lat_min = 3; lat_max = 5;
    base = seen_data_q.size();
    @(negedge clk);
    nonce_lo = 32'd0; nonce_hi = 32'd100; zero_bits = 8'd255; go = 1'b1;
    nstart = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      go = 1'b0;
      if (core_start) begin
        nstart++;
        if (nstart == 1) begin
          nonce_lo = 32'd50; nonce_hi = 32'd50; zero_bits = 8'd0; go = 1'b1;
        end
        if (nstart == 3) break;
      end
    end
    go = 1'b0;
    check_eq("abort_reach3", nstart, 3);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_flags", {found, exhausted, aborted}, 3'b001);
    check_eq("abort_count", hash_count, 32'd2);
    check_eq("abort_starts", seen_data_q.size() - base, 3);
    check_eq("abort_creset", core_reset, 1'b1);
    @(negedge clk);
    check_eq("abort_creset2", core_reset, 1'b0);
    check_eq("abort_hold", aborted, 1'b1);
    lat_min = 0; lat_max = 3;

    // Reset mid-sweep discards everything
    @(negedge clk);
    nonce_lo = 32'd0; nonce_hi = 32'd50; zero_bits = 8'd255; go = 1'b1;
    @(negedge clk); go = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mrst_busy", busy, 1'b0);
    check_eq("mrst_flags", {found, exhausted, aborted}, 3'b000);
    check_eq("mrst_count", hash_count, 32'd0);
    check_eq("mrst_creset", core_reset, 1'b1);
    reset_n = 1'b1;
    @(negedge clk);
    seed = $urandom();
    run_sweep(32'd20, 32'd25, 8'd3, "post_rst");

`ifdef NONCE_SWEEP_TIMEOUT_EN
    // Hung core: watchdog fires TO cycles after WAIT entry
    stub_hang = 1'b1;
    @(negedge clk);
    nonce_lo = 32'd0; nonce_hi = 32'd5; zero_bits = 8'd0; go = 1'b1;
    @(negedge clk); go = 1'b0;
    @(negedge clk);
    check_eq("to_start", core_start, 1'b1);
    k = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (timeout) begin
        k = c;
        break;
      end
    end
    check_eq("to_latency", k, TO + 1);
    check_eq("to_creset", core_reset, 1'b1);
    check_eq("to_busy", busy, 1'b0);
    check_eq("to_flags", {found, exhausted, aborted, timeout}, 4'b0001);
    check_eq("to_count", hash_count, 32'd0);
    stub_hang = 1'b0;
    run_sweep(32'd9, 32'd9, 8'd0, "post_to");
`else
    k = 0;
`endif

    check_eq("data_stable", stable_err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
